uart_tx: RTL and testbench

UART transmitter. Serialises one byte per request onto a single-wire asynchronous line using 8-N-1 framing by default, with optional parity and a second stop bit. Sits between a byte-producing controller (send/data_in handshake) and the external TX pin. Status flags report frame in progress and frame completion.

---
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per accepted request as
// start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// All outputs come straight from flops so the TX pin never glitches.
module uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data_in,
  output logic       data_tx,
  output logic       active_flag,
  output logic       done_flag
);

  // Cycle counter only needs to reach CLKS_PER_BIT-1; keep at least one bit.
  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic           ODD_PAR   = (PARITY == 2);
  localparam logic           HAS_PAR   = (PARITY != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_tx;
  logic          r_active;
  logic          r_done;
  logic          w_bit_end;

  // Last cycle of the current bit period; the counter wraps here.
  assign w_bit_end = (r_clk_cnt == LAST_CLK);

  // Frame sequencer: the line value for the next bit is registered on the
  // same edge that enters that bit, so data_tx lines up with the state.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_active  <= 1'b0;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          if (send) begin
            r_shift  <= data_in;
            r_parity <= (^data_in) ^ ODD_PAR;
            r_state  <= S_START;
            r_tx     <= 1'b0;
            r_active <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (HAS_PAR) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_state   <= S_STOP;
            r_tx      <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == LAST_STOP) begin
              r_bit_cnt <= '0;
              r_state   <= S_DONE;
              r_tx      <= 1'b1;
              r_active  <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // send is deliberately ignored here; a held request restarts from IDLE.
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
        default: begin
          r_state  <= S_IDLE;
          r_tx     <= 1'b1;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign data_tx     = r_tx;
  assign active_flag = r_active;
  assign done_flag   = r_done;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int N = 6;
  // Configurations under test: default, back-to-back, even, odd, even+2 stop, minimum CLKS_PER_BIT
  localparam int CPB_T[N] = '{87, 4, 4, 5, 3, 2};
  localparam int PAR_T[N] = '{0,  0, 1, 2, 1, 0};
  localparam int SB_T[N]  = '{1,  1, 1, 1, 2, 2};

  logic       clk;
  logic       reset;
  logic       snd [N];
  logic [7:0] din [N];
  logic       tx  [N];
  logic       act [N];
  logic       dn  [N];

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    #10;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  uart_tx #(.CLKS_PER_BIT(87), .PARITY(0), .STOP_BITS(1)) u0 (
    .sys_clk(clk), .reset(reset), .send(snd[0]), .data_in(din[0]),
    .data_tx(tx[0]), .active_flag(act[0]), .done_flag(dn[0]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u1 (
    .sys_clk(clk), .reset(reset), .send(snd[1]), .data_in(din[1]),
    .data_tx(tx[1]), .active_flag(act[1]), .done_flag(dn[1]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u2 (
    .sys_clk(clk), .reset(reset), .send(snd[2]), .data_in(din[2]),
    .data_tx(tx[2]), .active_flag(act[2]), .done_flag(dn[2]));
  uart_tx #(.CLKS_PER_BIT(5), .PARITY(2), .STOP_BITS(1)) u3 (
    .sys_clk(clk), .reset(reset), .send(snd[3]), .data_in(din[3]),
    .data_tx(tx[3]), .active_flag(act[3]), .done_flag(dn[3]));
  uart_tx #(.CLKS_PER_BIT(3), .PARITY(1), .STOP_BITS(2)) u4 (
    .sys_clk(clk), .reset(reset), .send(snd[4]), .data_in(din[4]),
    .data_tx(tx[4]), .active_flag(act[4]), .done_flag(dn[4]));
  uart_tx #(.CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(2)) u5 (
    .sys_clk(clk), .reset(reset), .send(snd[5]), .data_in(din[5]),
    .data_tx(tx[5]), .active_flag(act[5]), .done_flag(dn[5]));

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: list of line levels, one entry per bit period.
  function automatic int build_frame(input int par, input int sb, input logic [7:0] b,
                                     output logic bits [16]);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) bits[i] = 1'b1;
    bits[n++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[n++] = b[i];
    if (par != 0) bits[n++] = (($countones(b) % 2) == 1) ^ (par == 2);
    for (int i = 0; i < sb; i++) bits[n++] = 1'b1;
    return n;
  endfunction

  // ---------------- driver ----------------
  // Request a frame on instance k, then check every cycle of it, the DONE
  // cycle and the following IDLE cycle. Called with clk low before an edge.
  task automatic do_frame(input int k, input logic [7:0] b, input logic [7:0] next_b,
                          input bit hold);
    logic bits [16];
    int   nb;
    int   good;
    int   act_cycles;
    nb = build_frame(PAR_T[k], SB_T[k], b, bits);
    snd[k] = 1'b1;
    din[k] = b;
    @(negedge clk);
    if (!hold) snd[k] = 1'b0;
    din[k] = next_b;
    act_cycles = 0;
    for (int i = 0; i < nb; i++) begin
      good = 0;
      for (int c = 0; c < CPB_T[k]; c++) begin
        if (tx[k] === bits[i] && dn[k] === 1'b0) good++;
        if (act[k] === 1'b1) act_cycles++;
        @(negedge clk);
      end
      chk($sformatf("k%0d b%02h bit%0d", k, b, i), good, CPB_T[k]);
    end
    chk($sformatf("k%0d b%02h active_len", k, b), act_cycles, nb * CPB_T[k]);
    chk($sformatf("k%0d b%02h done_pulse", k, b), {29'd0, dn[k], act[k], tx[k]}, 32'h5);
    @(negedge clk);
    chk($sformatf("k%0d b%02h idle_after", k, b), {29'd0, dn[k], act[k], tx[k]}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int hi;
    logic [7:0] rb;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      snd[i] = 1'b0;
      din[i] = 8'h00;
    end
    #3;
    for (int i = 0; i < N; i++)
      chk($sformatf("k%0d reset_out", i), {29'd0, dn[i], act[i], tx[i]}, 32'h1);
    #5;
    reset = 1'b0;

    // Default config, 0x37, data_in swapped to 0xFF after acceptance.
    do_frame(0, 8'h37, 8'hFF, 1'b0);

    // Back-to-back with send held: 0xA5 then 0x00.
    do_frame(1, 8'hA5, 8'h00, 1'b1);
    do_frame(1, 8'h00, 8'h00, 1'b0);

    // Parity / stop-bit variants with 0x37, minimum CLKS_PER_BIT.
    do_frame(2, 8'h37, 8'h00, 1'b0);
    do_frame(3, 8'h37, 8'h00, 1'b0);
    do_frame(4, 8'h37, 8'h00, 1'b0);
    do_frame(5, 8'h37, 8'h00, 1'b0);

    // Random bytes on random small configs.
    for (int n = 0; n < 10; n++) begin
      k  = $urandom_range(N - 1, 1);
      rb = 8'($urandom);
      do_frame(k, rb, 8'($urandom), 1'b0);
    end

    // Mid-frame reset during data bit 3 of 0x00 on instance 1.
    snd[1] = 1'b1;
    din[1] = 8'h00;
    @(negedge clk);
    snd[1] = 1'b0;
    repeat (4 * CPB_T[1] + 1) @(negedge clk);
    chk("mid_pre_reset", {30'd0, act[1], tx[1]}, 32'h2);
    reset = 1'b1;
    #1;
    chk("mid_reset_now", {29'd0, dn[1], act[1], tx[1]}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hi = 0;
    for (int c = 0; c < 60; c++) begin
      if (dn[1] !== 1'b0 || act[1] !== 1'b0 || tx[1] !== 1'b1) hi++;
      @(negedge clk);
    end
    chk("mid_reset_quiet", hi, 0);
    do_frame(1, 8'h5A, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
